// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
//
// Groups the control, memory and IF/ID signals of the instruction fetch unit
// into one bundle. Clock and reset are not part of it and stay plain ports
// on the fetch unit.
//
// Signals:
//   Stall            hazard unit asks the fetch stage to hold PC and IF/ID
//   Flush            load a bubble into IF/ID on this edge
//   Redirect         branch/jump taken, PC takes RedirectTarget
//   RedirectTarget   byte address of the new fetch point
//   Instruction      word returned by InstructionMemory for Address
//   Address          current PC, drives InstructionMemory
//   IFID_Instruction registered instruction (0 = nop bubble)
//   IFID_PCPlus4     registered PC+4 belonging to IFID_Instruction
//   IFID_Valid       1 = IF/ID holds a real instruction
//   FetchCount       saturating count of valid instructions latched
//
// Modports:
//   master  the surrounding pipeline / memory side (drives the controls)
//   slave   the fetch unit itself
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);

    logic                   Stall;
    logic                   Flush;
    logic                   Redirect;
    logic [PC_WIDTH-1:0]    RedirectTarget;
    logic [INSTR_WIDTH-1:0] Instruction;
    logic [PC_WIDTH-1:0]    Address;
    logic [INSTR_WIDTH-1:0] IFID_Instruction;
    logic [PC_WIDTH-1:0]    IFID_PCPlus4;
    logic                   IFID_Valid;
    logic [31:0]            FetchCount;

    modport master (
        output Stall,
        output Flush,
        output Redirect,
        output RedirectTarget,
        output Instruction,
        input  Address,
        input  IFID_Instruction,
        input  IFID_PCPlus4,
        input  IFID_Valid,
        input  FetchCount
    );

    modport slave (
        input  Stall,
        input  Flush,
        input  Redirect,
        input  RedirectTarget,
        input  Instruction,
        output Address,
        output IFID_Instruction,
        output IFID_PCPlus4,
        output IFID_Valid,
        output FetchCount
    );

endinterface

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Program counter and fetch stage sitting directly in front of a purely
// combinational InstructionMemory. The PC drives the memory address with no
// extra latency; the returned word is captured into the IF/ID register on
// the next rising edge together with PC+4 and a valid flag. Supports stall,
// branch/jump redirect, flush (bubble insertion) and a saturating count of
// instructions latched as valid.
//
// Ports:
//   Clk   system clock, every state update happens on its rising edge
//   Rst   synchronous active-low reset
//   bus   instruction_fetch_unit_if.slave carrying controls, memory data,
//         the fetch address and the IF/ID register outputs
//
// Parameters:
//   PC_WIDTH     width of the PC and all PC-derived values
//   RESET_PC     PC loaded on reset, expected to be word aligned
//   INSTR_WIDTH  instruction word width
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                  INSTR_WIDTH = 32
) (
    input  logic                     Clk,
    input  logic                     Rst,
    instruction_fetch_unit_if.slave  bus
);

    // What the stage does on the coming edge once reset is out of the way.
    typedef enum logic [2:0] {
        ACT_ADVANCE,
        ACT_HOLD,
        ACT_FLUSH_ADVANCE,
        ACT_FLUSH_HOLD,
        ACT_REDIRECT
    } action_t;

    action_t                action;

    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [PC_WIDTH-1:0]    pc_plus4;
    logic [PC_WIDTH-1:0]    redirect_pc;

    logic [INSTR_WIDTH-1:0] ifid_instruction;
    logic [INSTR_WIDTH-1:0] ifid_instruction_next;
    logic [PC_WIDTH-1:0]    ifid_pc_plus4;
    logic [PC_WIDTH-1:0]    ifid_pc_plus4_next;
    logic                   ifid_valid;
    logic                   ifid_valid_next;

    logic [31:0]            fetch_count;
    logic [31:0]            fetch_count_next;
    logic [31:0]            fetch_count_inc;

    // Sequential PC wraps naturally at 2^PC_WIDTH. Redirect targets are
    // forced onto a word boundary by masking the two low bits.
    assign pc_plus4    = pc + PC_WIDTH'(4);
    assign redirect_pc = bus.RedirectTarget & ~PC_WIDTH'(3);

    // The counter sticks at all ones instead of rolling back to zero.
    assign fetch_count_inc = (fetch_count == 32'hFFFF_FFFF) ? fetch_count
                                                            : fetch_count + 32'd1;

    // Priority decode of the control inputs: a redirect wins over everything,
    // a flush wins over a plain stall (but still honours the stall for the
    // PC), and a stall alone freezes the whole stage.
    always_comb begin
        action = ACT_ADVANCE;
        if (bus.Redirect) begin
            action = ACT_REDIRECT;
        end else if (bus.Flush) begin
            action = bus.Stall ? ACT_FLUSH_HOLD : ACT_FLUSH_ADVANCE;
        end else if (bus.Stall) begin
            action = ACT_HOLD;
        end
    end

    // Next-state values for the PC, the IF/ID register and the counter.
    // Everything defaults to holding; each action only overrides what it
    // changes. A bubble is an all-zero instruction (sll $0,$0,0) with
    // PCPlus4 and Valid cleared.
    always_comb begin
        pc_next               = pc;
        ifid_instruction_next = ifid_instruction;
        ifid_pc_plus4_next    = ifid_pc_plus4;
        ifid_valid_next       = ifid_valid;
        fetch_count_next      = fetch_count;

        case (action)
            ACT_REDIRECT: begin
                pc_next               = redirect_pc;
                ifid_instruction_next = '0;
                ifid_pc_plus4_next    = '0;
                ifid_valid_next       = 1'b0;
            end
            ACT_FLUSH_HOLD: begin
                ifid_instruction_next = '0;
                ifid_pc_plus4_next    = '0;
                ifid_valid_next       = 1'b0;
            end
            ACT_FLUSH_ADVANCE: begin
                pc_next               = pc_plus4;
                ifid_instruction_next = '0;
                ifid_pc_plus4_next    = '0;
                ifid_valid_next       = 1'b0;
            end
            ACT_HOLD: begin
                pc_next = pc;
            end
            ACT_ADVANCE: begin
                pc_next               = pc_plus4;
                ifid_instruction_next = bus.Instruction;
                ifid_pc_plus4_next    = pc_plus4;
                ifid_valid_next       = 1'b1;
                fetch_count_next      = fetch_count_inc;
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

    // State register. Reset is sampled on the clock edge and overrides all
    // other inputs, so a mid-run reset never leaves a partial update behind.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            pc               <= RESET_PC;
            ifid_instruction <= '0;
            ifid_pc_plus4    <= '0;
            ifid_valid       <= 1'b0;
            fetch_count      <= '0;
        end else begin
            pc               <= pc_next;
            ifid_instruction <= ifid_instruction_next;
            ifid_pc_plus4    <= ifid_pc_plus4_next;
            ifid_valid       <= ifid_valid_next;
            fetch_count      <= fetch_count_next;
        end
    end

    // The memory address is the PC register itself; all other outputs come
    // straight from the IF/ID register and the counter.
    assign bus.Address          = pc;
    assign bus.IFID_Instruction = ifid_instruction;
    assign bus.IFID_PCPlus4     = ifid_pc_plus4;
    assign bus.IFID_Valid       = ifid_valid;
    assign bus.FetchCount       = fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. Two instances are used: one
// with RESET_PC = 0 for the main sequences and one with RESET_PC =
// 0xFFFF_FFF8 for the PC wrap-around and mid-run reset. A combinational
// memory model returns 0x1000_0000 + Address[11:2] for every address.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic clk;
    logic rst_a;
    logic rst_b;

    int check_count;
    int pass_count;

    instruction_fetch_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus_a ();
    instruction_fetch_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus_b ();

    instruction_fetch_unit #(
        .PC_WIDTH    (32),
        .RESET_PC    (32'h0000_0000),
        .INSTR_WIDTH (32)
    ) dut_a (
        .Clk (clk),
        .Rst (rst_a),
        .bus (bus_a)
    );

    instruction_fetch_unit #(
        .PC_WIDTH    (32),
        .RESET_PC    (32'hFFFF_FFF8),
        .INSTR_WIDTH (32)
    ) dut_b (
        .Clk (clk),
        .Rst (rst_b),
        .bus (bus_b)
    );

    // Memory model: word k holds 0x1000_0000 + k.
    assign bus_a.Instruction = 32'h1000_0000 + {22'd0, bus_a.Address[11:2]};
    assign bus_b.Instruction = 32'h1000_0000 + {22'd0, bus_b.Address[11:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive the controls of instance A, run the given number of rising
    // edges and return at the following falling edge, ready to sample.
    task automatic applyStimulus(input logic rst, input logic stall, input logic flush,
                                 input logic redirect, input logic [31:0] target,
                                 input int edges);
        rst_a                = rst;
        bus_a.Stall          = stall;
        bus_a.Flush          = flush;
        bus_a.Redirect       = redirect;
        bus_a.RedirectTarget = target;
        repeat (edges) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;

        rst_b                = 1'b0;
        bus_b.Stall          = 1'b0;
        bus_b.Flush          = 1'b0;
        bus_b.Redirect       = 1'b0;
        bus_b.RedirectTarget = 32'h0;

        // Reset with competing controls asserted: they must be ignored.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 2);
        checkOutput("reset_address",  bus_a.Address,          32'h0);
        checkOutput("reset_valid",    32'(bus_a.IFID_Valid),  32'h0);
        checkOutput("reset_instr",    bus_a.IFID_Instruction, 32'h0);
        checkOutput("reset_pcplus4",  bus_a.IFID_PCPlus4,     32'h0);
        checkOutput("reset_count",    bus_a.FetchCount,       32'h0);

        // Five free-running fetches.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5);
        checkOutput("seq_address",  bus_a.Address,          32'h14);
        checkOutput("seq_instr",    bus_a.IFID_Instruction, 32'h1000_0004);
        checkOutput("seq_pcplus4",  bus_a.IFID_PCPlus4,     32'h14);
        checkOutput("seq_valid",    32'(bus_a.IFID_Valid),  32'h1);
        checkOutput("seq_count",    bus_a.FetchCount,       32'd5);

        // Restart and advance to Address 0x8, then stall for three edges.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2);
        checkOutput("pre_stall_address", bus_a.Address, 32'h8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1);
            checkOutput("stall_address", bus_a.Address,          32'h8);
            checkOutput("stall_instr",   bus_a.IFID_Instruction, 32'h1000_0001);
            checkOutput("stall_count",   bus_a.FetchCount,       32'd2);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1);
        checkOutput("unstall_address", bus_a.Address,          32'hC);
        checkOutput("unstall_instr",   bus_a.IFID_Instruction, 32'h1000_0002);
        checkOutput("unstall_count",   bus_a.FetchCount,       32'd3);

        // Misaligned redirect while stalled: target truncated, bubble loaded.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h43, 1);
        checkOutput("redir_address", bus_a.Address,          32'h40);
        checkOutput("redir_valid",   32'(bus_a.IFID_Valid),  32'h0);
        checkOutput("redir_instr",   bus_a.IFID_Instruction, 32'h0);
        checkOutput("redir_pcplus4", bus_a.IFID_PCPlus4,     32'h0);
        checkOutput("redir_count",   bus_a.FetchCount,       32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1);
        checkOutput("post_redir_instr",   bus_a.IFID_Instruction, 32'h1000_0010);
        checkOutput("post_redir_pcplus4", bus_a.IFID_PCPlus4,     32'h44);
        checkOutput("post_redir_count",   bus_a.FetchCount,       32'd4);

        // Redirect with flush also asserted still redirects; go to 0x20.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 1);
        checkOutput("redir_flush_address", bus_a.Address, 32'h20);

        // Flush without stall: PC advances, bubble loaded, count unchanged.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1);
        checkOutput("flush_address", bus_a.Address,          32'h24);
        checkOutput("flush_valid",   32'(bus_a.IFID_Valid),  32'h0);
        checkOutput("flush_instr",   bus_a.IFID_Instruction, 32'h0);
        checkOutput("flush_count",   bus_a.FetchCount,       32'd4);

        // Free edge, then flush with stall: PC held, bubble loaded.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1);
        checkOutput("refill_instr", bus_a.IFID_Instruction, 32'h1000_0009);
        checkOutput("refill_count", bus_a.FetchCount,       32'd5);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1);
        checkOutput("flush_stall_address", bus_a.Address,         32'h28);
        checkOutput("flush_stall_valid",   32'(bus_a.IFID_Valid), 32'h0);
        checkOutput("flush_stall_count",   bus_a.FetchCount,      32'd5);

        // Mid-run reset on instance A with a redirect pending.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1);
        checkOutput("midreset_a_address", bus_a.Address,    32'h0);
        checkOutput("midreset_a_count",   bus_a.FetchCount, 32'h0);

        // Wrap-around on instance B.
        rst_b = 1'b1;
        checkOutput("b_reset_address", bus_b.Address, 32'hFFFF_FFF8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("wrap_address", bus_b.Address,          32'h0);
        checkOutput("wrap_pcplus4", bus_b.IFID_PCPlus4,     32'h0);
        checkOutput("wrap_instr",   bus_b.IFID_Instruction, 32'h1000_03FF);
        checkOutput("wrap_count",   bus_b.FetchCount,       32'd2);

        rst_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_b_address", bus_b.Address,         32'hFFFF_FFF8);
        checkOutput("midreset_b_count",   bus_b.FetchCount,      32'h0);
        checkOutput("midreset_b_valid",   32'(bus_b.IFID_Valid), 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
